sdram_auto_refresh: RTL and testbench

//  Periodic auto-refresh engine sitting directly downstream of sdram_init.

---
 rtl/sdram_auto_refresh_pkg.sv | 22 ++
 rtl/sdram_auto_refresh_if.sv | 30 +++
 rtl/sdram_ref_timer.sv | 48 ++++
 rtl/sdram_auto_refresh.sv | 145 ++++++++++++++
 tb/tb_sdram_auto_refresh.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_auto_refresh_pkg.sv
// Shared SDRAM refresh constants: command encodings {Cs_n,Ras_n,Cas_n,We_n},
// default timing and address width, plus a small integer helper.
package sdram_auto_refresh_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int ASIZE_DEF      = 12;
    localparam int REF_PERIOD_DEF = 780;
    localparam int TRP_CLK_DEF    = 2;
    localparam int TRFC_CLK_DEF   = 7;

    // Address bit that selects "all banks" on a PRECHARGE.
    localparam int A10_BIT = 10;
    localparam int STATE_W = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_auto_refresh_if.sv
// Arbiter-facing bus of the auto-refresh engine: grant handshake, status flags,
// and the command/address outputs muxed onto the SDRAM pins by the arbiter.
interface sdram_auto_refresh_if
    import sdram_auto_refresh_pkg::*;
#(
    parameter int ASIZE = ASIZE_DEF
);
    // Handshake: Ref_req rises on interval expiry and holds until the arbiter
    // answers with Ref_en while the engine is idle; that edge consumes the grant.
    // The engine owns Command/Saddr until the cycle Ref_done pulses, then releases.
    logic               Init_done;
    logic               Ref_en;
    logic               Ref_req;
    logic               Ref_done;
    logic               Ref_miss;
    logic [3:0]         Command;
    logic [ASIZE-1:0]   Saddr;
    logic [STATE_W-1:0] dbg_state;

    modport slave (
        input  Init_done, Ref_en,
        output Ref_req, Ref_done, Ref_miss, Command, Saddr, dbg_state
    );

    modport master (
        output Init_done, Ref_en,
        input  Ref_req, Ref_done, Ref_miss, Command, Saddr, dbg_state
    );

endinterface

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval counter; raises a sticky request at each
// terminal count and flags a miss when the previous request was never granted.
module sdram_ref_timer
    import sdram_auto_refresh_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic init_done,
    input  logic grant,
    output logic ref_req,
    output logic ref_miss
);

    localparam int            CW     = $clog2(REF_PERIOD + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(REF_PERIOD - 1);

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc = (cnt == TC_VAL);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt      <= '0;
            ref_req  <= 1'b0;
            ref_miss <= 1'b0;
        end else if (!init_done) begin
            cnt      <= '0;
            ref_req  <= 1'b0;
            ref_miss <= 1'b0;
        end else begin
            cnt <= tc ? '0 : cnt + CW'(1);
            // A fresh interval expiring on the grant edge re-arms the request
            // instead of counting as a miss.
            if (tc) begin
                ref_req <= 1'b1;
                if (ref_req && !grant) begin
                    ref_miss <= 1'b1;
                end
            end else if (grant) begin
                ref_req <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_auto_refresh.sv
// Periodic SDRAM auto-refresh engine. Define SDRAM_REF_PRECHARGE_EN to issue a
// PRECHARGE-all (A10=1) plus tRP wait ahead of each AUTO REFRESH.
module sdram_auto_refresh
    import sdram_auto_refresh_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF,
    parameter int TRP_CLK    = TRP_CLK_DEF,
    parameter int TRFC_CLK   = TRFC_CLK_DEF,
    parameter int ASIZE      = ASIZE_DEF
) (
    input logic                  Clk,
    input logic                  Rst_n,
    sdram_auto_refresh_if.slave  bus
);

    localparam int             WCW        = $clog2(max_int(TRP_CLK, TRFC_CLK)) + 1;
    localparam logic [WCW-1:0] TRFC_LAST  = WCW'(TRFC_CLK - 1);
`ifdef SDRAM_REF_PRECHARGE_EN
    localparam logic [WCW-1:0] TRP_LAST   = WCW'(TRP_CLK - 1);
`endif

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_AREF      = 3'd1,
`ifdef SDRAM_REF_PRECHARGE_EN
        ST_PRE       = 3'd3,
        ST_WAIT_TRP  = 3'd4,
`endif
        ST_WAIT_TRFC = 3'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [ASIZE-1:0] saddr_q, saddr_d;
    logic             done_q, done_d;
    logic             grant;

    assign grant = bus.Init_done && (state_q == ST_IDLE) && bus.Ref_req && bus.Ref_en;

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_timer (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .init_done (bus.Init_done),
        .grant     (grant),
        .ref_req   (bus.Ref_req),
        .ref_miss  (bus.Ref_miss)
    );

    // Command/Saddr are computed for the state being entered, so each state
    // occupies exactly the cycle in which its command is on the bus.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cmd_d   = CMD_NOP;
        saddr_d = '0;
        done_d  = 1'b0;
        if (!bus.Init_done) begin
            state_d = ST_IDLE;
            wait_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
`ifdef SDRAM_REF_PRECHARGE_EN
                        state_d          = ST_PRE;
                        cmd_d            = CMD_PRE;
                        saddr_d[A10_BIT] = 1'b1;
`else
                        state_d = ST_AREF;
                        cmd_d   = CMD_AREF;
`endif
                    end
                end
`ifdef SDRAM_REF_PRECHARGE_EN
                ST_PRE: begin
                    if (TRP_CLK == 1) begin
                        state_d = ST_AREF;
                        cmd_d   = CMD_AREF;
                    end else begin
                        state_d = ST_WAIT_TRP;
                        wait_d  = WCW'(1);
                    end
                end
                ST_WAIT_TRP: begin
                    if (wait_q == TRP_LAST) begin
                        state_d = ST_AREF;
                        cmd_d   = CMD_AREF;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + WCW'(1);
                    end
                end
`endif
                ST_AREF: begin
                    if (TRFC_CLK == 1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_TRFC;
                        wait_d  = WCW'(1);
                    end
                end
                ST_WAIT_TRFC: begin
                    if (wait_q == TRFC_LAST) begin
                        state_d = ST_IDLE;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + WCW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end
            endcase
            // Done marks the final cycle the engine owns the bus.
            done_d = ((state_d == ST_AREF) && (TRFC_CLK == 1)) ||
                     ((state_d == ST_WAIT_TRFC) && (wait_d == TRFC_LAST));
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            cmd_q   <= CMD_NOP;
            saddr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cmd_q   <= cmd_d;
            saddr_q <= saddr_d;
            done_q  <= done_d;
        end
    end

    assign bus.Command   = cmd_q;
    assign bus.Saddr     = saddr_q;
    assign bus.Ref_done  = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sdram_auto_refresh.sv
// Directed bench for sdram_auto_refresh: reset/init gating, request timing,
// starvation miss, refresh sequence, abort, and grant/terminal-count overlap.
module tb_sdram_auto_refresh;

    localparam int REF_PERIOD = 780;
    localparam int TRP        = 2;
    localparam int TRFC       = 7;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
`ifdef SDRAM_REF_PRECHARGE_EN
    localparam int          SEQ_LEN    = 9;
    localparam int          AREF_AT    = 3;
    localparam logic [3:0]  FIRST_CMD  = 4'b0010;
    localparam logic [11:0] FIRST_ADDR = 12'h400;
`else
    localparam int          SEQ_LEN    = 7;
    localparam int          AREF_AT    = 1;
    localparam logic [3:0]  FIRST_CMD  = 4'b0001;
    localparam logic [11:0] FIRST_ADDR = 12'h000;
`endif

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    int since_pre  = 1000;
    int since_aref = 1000;

    // expected {Ref_done, Command, Saddr} per cycle
    logic [16:0] exp_q[$];

    sdram_auto_refresh_if #(.ASIZE(12)) bus ();

    sdram_auto_refresh #(
        .REF_PERIOD (REF_PERIOD),
        .TRP_CLK    (TRP),
        .TRFC_CLK   (TRFC),
        .ASIZE      (12)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    // command spacing monitor (tRP after PRE, tRFC after AREF, legal encodings)
    always @(negedge clk) begin
        since_pre  <= (bus.Command === PRE)  ? 0 : since_pre + 1;
        since_aref <= (bus.Command === AREF) ? 0 : since_aref + 1;
        if (bus.Command !== NOP &&
            ((since_aref + 1 < TRFC) ||
             (bus.Command === AREF && since_pre + 1 < TRP) ||
             (bus.Command !== PRE && bus.Command !== AREF))) begin
            viol <= viol + 1;
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] seq_entry(input int i);
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic        done;
        cmd  = NOP;
        addr = 12'h000;
        done = (i == SEQ_LEN);
        if (i == 1) begin
            cmd  = FIRST_CMD;
            addr = FIRST_ADDR;
        end
        if (i == AREF_AT) cmd = AREF;
        return {done, cmd, addr};
    endfunction

    task automatic check_scoreboard(input string tag);
        logic [16:0] exp;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, {15'd0, bus.Ref_done, bus.Command, bus.Saddr}, {15'd0, exp});
        end
    endtask

    initial begin
        bus.Init_done = 1'b0;
        bus.Ref_en    = 1'b0;
        rst_n         = 1'b0;
        step(1);
        chk("rst_req",   32'(bus.Ref_req),   32'd0);
        chk("rst_done",  32'(bus.Ref_done),  32'd0);
        chk("rst_miss",  32'(bus.Ref_miss),  32'd0);
        chk("rst_cmd",   32'(bus.Command),   32'(NOP));
        chk("rst_saddr", 32'(bus.Saddr),     32'd0);
        chk("rst_state", 32'(bus.dbg_state), 32'd0);
        for (int i = 0; i < 200; i++) begin
            step(1);
            chk("rst_hold_req", 32'(bus.Ref_req), 32'd0);
            chk("rst_hold_cmd", 32'(bus.Command), 32'(NOP));
        end

        // Init_done low gates everything, stray Ref_en ignored
        rst_n      = 1'b1;
        bus.Ref_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            chk("gate_req",   32'(bus.Ref_req),   32'd0);
            chk("gate_cmd",   32'(bus.Command),   32'(NOP));
            chk("gate_state", 32'(bus.dbg_state), 32'd0);
        end

        // first request lands exactly REF_PERIOD cycles after Init_done
        bus.Ref_en    = 1'b0;
        bus.Init_done = 1'b1;
        step(REF_PERIOD - 1);
        chk("first_req_early", 32'(bus.Ref_req), 32'd0);
        step(1);
        chk("first_req",      32'(bus.Ref_req),  32'd1);
        chk("first_req_miss", 32'(bus.Ref_miss), 32'd0);
        chk("first_req_cmd",  32'(bus.Command),  32'(NOP));

        // starvation: second terminal count with request pending sets miss
        step(REF_PERIOD - 1);
        chk("starve_req",        32'(bus.Ref_req),  32'd1);
        chk("starve_miss_early", 32'(bus.Ref_miss), 32'd0);
        step(1);
        chk("starve_miss",     32'(bus.Ref_miss), 32'd1);
        chk("starve_req_hold", 32'(bus.Ref_req),  32'd1);

        // grant; Ref_en held through the sequence must be ignored
        bus.Ref_en = 1'b1;
        for (int i = 1; i <= SEQ_LEN + 1; i++) exp_q.push_back(seq_entry(i));
        for (int i = 1; i <= SEQ_LEN + 1; i++) begin
            step(1);
            check_scoreboard("seq");
            if (i == 1) chk("seq_req_clear", 32'(bus.Ref_req), 32'd0);
        end
        chk("seq_idle",      32'(bus.dbg_state), 32'd0);
        chk("seq_miss_stky", 32'(bus.Ref_miss),  32'd1);
        chk("seq_req_idle",  32'(bus.Ref_req),   32'd0);
        bus.Ref_en = 1'b0;

        // dropping Init_done clears sticky flags
        bus.Init_done = 1'b0;
        step(1);
        chk("drop_miss", 32'(bus.Ref_miss), 32'd0);
        chk("drop_req",  32'(bus.Ref_req),  32'd0);
        step(2);

        // abort mid WAIT_TRFC
        bus.Init_done = 1'b1;
        step(REF_PERIOD);
        chk("abort_req", 32'(bus.Ref_req), 32'd1);
        bus.Ref_en = 1'b1;
        step(AREF_AT + 2);
        chk("abort_busy", 32'(bus.dbg_state != 3'd0), 32'd1);
        chk("abort_pre_cmd", 32'(bus.Command), 32'(NOP));
        bus.Init_done = 1'b0;
        bus.Ref_en    = 1'b0;
        step(1);
        chk("abort_cmd",   32'(bus.Command),   32'(NOP));
        chk("abort_state", 32'(bus.dbg_state), 32'd0);
        chk("abort_req_clr", 32'(bus.Ref_req), 32'd0);
        chk("abort_done",  32'(bus.Ref_done),  32'd0);
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("abort_no_done", 32'(bus.Ref_done), 32'd0);
            chk("abort_nop",     32'(bus.Command),  32'(NOP));
        end

        // grant coincident with terminal count, then back-to-back grant
        bus.Init_done = 1'b1;
        step(REF_PERIOD - 1);
        chk("coinc_req_early", 32'(bus.Ref_req), 32'd0);
        step(1);
        chk("coinc_req_first", 32'(bus.Ref_req), 32'd1);
        step(REF_PERIOD - 1);
        bus.Ref_en = 1'b1;
        for (int i = 1; i <= SEQ_LEN; i++) exp_q.push_back(seq_entry(i));
        exp_q.push_back({1'b0, NOP, 12'h000});
        exp_q.push_back(seq_entry(1));
        for (int i = 1; i <= SEQ_LEN + 2; i++) begin
            step(1);
            check_scoreboard("coinc_seq");
            if (i == 1) begin
                chk("coinc_req_stays", 32'(bus.Ref_req),  32'd1);
                chk("coinc_no_miss",   32'(bus.Ref_miss), 32'd0);
            end
            if (i == SEQ_LEN + 1) begin
                chk("b2b_idle",    32'(bus.dbg_state), 32'd0);
                chk("b2b_pending", 32'(bus.Ref_req),   32'd1);
            end
        end
        chk("b2b_req_clr", 32'(bus.Ref_req), 32'd0);
        bus.Ref_en = 1'b0;
        step(SEQ_LEN);
        chk("b2b_end_idle", 32'(bus.dbg_state), 32'd0);
        chk("b2b_end_done", 32'(bus.Ref_done),  32'd0);

        chk("timing_viol", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
